// File: rtl/ppcache_ctrl.sv
// ppcache_ctrl
// -----------------------------------------------------------------------------
// Sequencing controller for the SpMV ping-pong vector cache. Segment
// descriptors open a fill of the write bank; producer beats are gated into
// that bank until the segment is complete. A completed fill is handed to the
// drain side with a one-cycle bank-swap pulse, but only once the previous
// drain has finished. Filling of the next segment overlaps draining of the
// current one.
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   seg_start_valid/ready, seg_len
//                       segment descriptor handshake, seg_len legal 1..DATA_DEPTH
//   wr_valid/wr_ready   producer beat handshake (beats land in fill_bank)
//   rd_req/rd_grant     consumer beat request/grant from the drain bank
//   seg_done            one-cycle pulse the cycle after a segment's last grant
//   cache_select_valid  bank-swap pulse to the cache
//   cache_select        bank that becomes the read bank (1 during INIT)
//   cache_input_valid   cache write strobe (accepted producer beat)
//   cache_output_ready  cache read advance (equals rd_grant)
//   fill_bank           bank currently being written
//   err_len             sticky: a descriptor with an illegal length was seen
//   dbg_state           current FSM state (state_t encoding)
//
// Handshakes: a descriptor or write beat transfers in a cycle where both
// valid and ready are high. Ready never depends on valid, so a source may
// hold valid and wait. rd_req/rd_grant behave the same way: a beat advances
// only when rd_grant is high. Nothing transfers during INIT or SWAP.
// -----------------------------------------------------------------------------
module ppcache_ctrl #(
  parameter int DATA_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  seg_start_valid,
  input  logic [ADDR_WIDTH:0]   seg_len,
  output logic                  seg_start_ready,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  rd_req,
  output logic                  rd_grant,
  output logic                  seg_done,
  output logic                  cache_select_valid,
  output logic                  cache_select,
  output logic                  cache_input_valid,
  output logic                  cache_output_ready,
  output logic                  fill_bank,
  output logic                  err_len,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  // FSM
  state_t state_q;
  state_t state_d;

  // Fill side
  logic                fill_active_q;
  logic                fill_full_q;
  logic [ADDR_WIDTH:0] fill_cnt_q;
  logic [ADDR_WIDTH:0] fill_len_q;
  logic                fill_bank_q;
  logic                err_len_q;

  // Drain side
  logic                drain_active_q;
  logic [ADDR_WIDTH:0] drain_cnt_q;
  logic [ADDR_WIDTH:0] drain_len_q;
  logic                seg_done_q;

  // Combinational decode
  logic                run;
  logic                swap_go;
  logic                sel_valid;
  logic                sel_bank;
  logic                seg_acc;
  logic                len_legal;
  logic                wr_acc;
  logic                rd_acc;
  logic [ADDR_WIDTH:0] fill_cnt_nxt;
  logic [ADDR_WIDTH:0] drain_cnt_nxt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and swap-pulse outputs
  // A swap is only taken when the fill bank is complete (fill_full implies
  // fill_active is clear) and the drain side is idle, because the cache's
  // select resets both bank pointers.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    run       = 1'b0;
    swap_go   = 1'b0;
    sel_valid = 1'b0;
    sel_bank  = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Selecting bank 1 for reading points the cache's writes at bank 0.
        // The pulse is held off while reset is asserted so every output
        // except cache_select is quiet during reset.
        sel_valid = rstn;
        sel_bank  = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        run = 1'b1;
        if (fill_full_q && !drain_active_q) begin
          swap_go = 1'b1;
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        sel_valid = 1'b1;
        sel_bank  = fill_bank_q;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign seg_start_ready = run & ~fill_active_q & ~fill_full_q;
  assign seg_acc         = seg_start_valid & seg_start_ready;
  assign len_legal       = (seg_len != '0) && (seg_len <= MAX_LEN);

  assign wr_ready        = run & fill_active_q;
  assign wr_acc          = wr_valid & wr_ready;
  assign fill_cnt_nxt    = fill_cnt_q + ONE;

  assign rd_grant        = run & drain_active_q & rd_req;
  assign rd_acc          = rd_grant;
  assign drain_cnt_nxt   = drain_cnt_q + ONE;

  // ---------------------------------------------------------------------------
  // Fill side. seg_acc and wr_acc cannot coincide (ready excludes an active
  // fill), and swap_go requires fill_full, which excludes an active fill.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_active_q <= 1'b0;
      fill_full_q   <= 1'b0;
      fill_cnt_q    <= '0;
      fill_len_q    <= '0;
      err_len_q     <= 1'b0;
    end else begin
      if (seg_acc) begin
        if (len_legal) begin
          fill_len_q    <= seg_len;
          fill_cnt_q    <= '0;
          fill_active_q <= 1'b1;
        end else begin
          // Illegal descriptors are consumed without starting a fill.
          err_len_q <= 1'b1;
        end
      end
      if (wr_acc) begin
        fill_cnt_q <= fill_cnt_nxt;
        if (fill_cnt_nxt == fill_len_q) begin
          fill_active_q <= 1'b0;
          fill_full_q   <= 1'b1;
        end
      end
      if (swap_go) begin
        fill_full_q <= 1'b0;
      end
    end
  end

  // The fill bank flips when SWAP completes; INIT re-establishes bank 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_bank_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      fill_bank_q <= 1'b0;
    end else if (state_q == ST_SWAP) begin
      fill_bank_q <= ~fill_bank_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain side. The completed fill's length is captured on entry to SWAP;
  // granting starts the cycle after SWAP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_active_q <= 1'b0;
      drain_cnt_q    <= '0;
      drain_len_q    <= '0;
      seg_done_q     <= 1'b0;
    end else begin
      seg_done_q <= 1'b0;
      if (swap_go) begin
        drain_len_q <= fill_len_q;
        drain_cnt_q <= '0;
      end
      if (state_q == ST_SWAP) begin
        drain_active_q <= 1'b1;
      end
      if (rd_acc) begin
        drain_cnt_q <= drain_cnt_nxt;
        if (drain_cnt_nxt == drain_len_q) begin
          drain_active_q <= 1'b0;
          seg_done_q     <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign seg_done           = seg_done_q;
  assign cache_select_valid = sel_valid;
  assign cache_select       = sel_bank;
  assign cache_input_valid  = wr_acc;
  assign cache_output_ready = rd_grant;
  assign fill_bank          = fill_bank_q;
  assign err_len            = err_len_q;
  assign dbg_state          = state_q;

endmodule
